// File: rtl/controlador_dma_hd_pkg.sv
// ---------------------------------------------------------------------------
// controlador_dma_hd_pkg
// Shared definitions for the HD <-> data-memory DMA sequencer:
//   - estado_t   : sequencer state encoding (IDLE=0, RD=1, WR=2, FIN=3)
//   - DIR_*      : transfer direction constants for cmd_dir
//   - DEF_*      : default widths for memory address, HD address and length
// ---------------------------------------------------------------------------
package controlador_dma_hd_pkg;

  localparam int DEF_MEM_ADDR_W = 10;
  localparam int DEF_HD_ADDR_W  = 16;
  localparam int DEF_LEN_W      = 9;
  localparam int DATA_W         = 32;

  localparam logic DIR_HD2MEM = 1'b0;
  localparam logic DIR_MEM2HD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } estado_t;

endpackage

// File: rtl/controlador_dma_hd_if.sv
// ---------------------------------------------------------------------------
// controlador_dma_hd_if
// Bundles every bus the DMA sequencer touches:
//   command   : cmd_valid, cmd_dir, cmd_hd_addr, cmd_mem_addr, cmd_len
//   core side : cpu_mem_we, cpu_mem_addr, cpu_mem_wdata
//   memory    : mem_we, mem_addr, mem_wdata (out), mem_rdata (in, 1-cycle latency)
//   HD        : hd_we, hd_addr, hd_wdata (out), hd_rdata (in, 1-cycle latency)
//   status    : stall, busy, done, checksum
// Modports:
//   master : the sequencer (drives memory/HD ports and status)
//   slave  : the surrounding system (core, memory, HD model)
// ---------------------------------------------------------------------------
interface controlador_dma_hd_if
  import controlador_dma_hd_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int HD_ADDR_W  = DEF_HD_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W
);

  logic                  cmd_valid;
  logic                  cmd_dir;
  logic [HD_ADDR_W-1:0]  cmd_hd_addr;
  logic [MEM_ADDR_W-1:0] cmd_mem_addr;
  logic [LEN_W-1:0]      cmd_len;

  logic                  cpu_mem_we;
  logic [DATA_W-1:0]     cpu_mem_addr;
  logic [DATA_W-1:0]     cpu_mem_wdata;

  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  hd_we;
  logic [HD_ADDR_W-1:0]  hd_addr;
  logic [DATA_W-1:0]     hd_wdata;
  logic [DATA_W-1:0]     hd_rdata;

  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     checksum;

  modport master (
    input  cmd_valid, cmd_dir, cmd_hd_addr, cmd_mem_addr, cmd_len,
    input  cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    input  mem_rdata, hd_rdata,
    output mem_we, mem_addr, mem_wdata,
    output hd_we, hd_addr, hd_wdata,
    output stall, busy, done, checksum
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_hd_addr, cmd_mem_addr, cmd_len,
    output cpu_mem_we, cpu_mem_addr, cpu_mem_wdata,
    output mem_rdata, hd_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  hd_we, hd_addr, hd_wdata,
    input  stall, busy, done, checksum
  );

endinterface

// File: rtl/controlador_dma_hd_contador.sv
// ---------------------------------------------------------------------------
// contador_enderecos_dma
// Address and length counters for the DMA sequencer.
//   clk, reset   : clock, asynchronous active-low reset
//   load         : capture hd_ini / mem_ini / len_ini
//   step         : advance both addresses by one word, decrement remaining
//   hd_addr      : current HD word address (wraps modulo 2^HD_ADDR_W)
//   mem_addr     : current memory word address (wraps modulo 2^MEM_ADDR_W)
//   chega_zero   : remaining count is 1, i.e. the next step empties it
// ---------------------------------------------------------------------------
module contador_enderecos_dma #(
  parameter int HD_ADDR_W  = 16,
  parameter int MEM_ADDR_W = 10,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [HD_ADDR_W-1:0]  hd_ini,
  input  logic [MEM_ADDR_W-1:0] mem_ini,
  input  logic [LEN_W-1:0]      len_ini,
  output logic [HD_ADDR_W-1:0]  hd_addr,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  chega_zero
);

  logic [HD_ADDR_W-1:0]  hd_q;
  logic [MEM_ADDR_W-1:0] mem_q;
  logic [LEN_W-1:0]      rem_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hd_q  <= '0;
      mem_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      hd_q  <= hd_ini;
      mem_q <= mem_ini;
      rem_q <= len_ini;
    end else if (step) begin
      // Plain binary increment: addresses wrap silently at 2^width.
      hd_q  <= hd_q + HD_ADDR_W'(1);
      mem_q <= mem_q + MEM_ADDR_W'(1);
      rem_q <= rem_q - LEN_W'(1);
    end
  end

  assign hd_addr    = hd_q;
  assign mem_addr   = mem_q;
  assign chega_zero = (rem_q == LEN_W'(1));

endmodule

// File: rtl/controlador_dma_hd.sv
// ---------------------------------------------------------------------------
// controlador_dma_hd
// Block-copy sequencer between the HD model and data memory, triggered by an
// HD instruction from the control unit. Stalls the core for the whole copy,
// owns the data-memory port while copying and passes the core's requests
// through when idle.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : controlador_dma_hd_if.master (command, core request, memory
//            port, HD port, stall/busy/done/checksum)
// Each word takes two cycles: RD presents the source address, WR writes the
// source read data (1-cycle latency) to the destination.
// Optional feature: define DMA_CHECKSUM_EN to build a running XOR of all
// transferred words; otherwise checksum is tied to zero.
// ---------------------------------------------------------------------------
module controlador_dma_hd
  import controlador_dma_hd_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int HD_ADDR_W  = DEF_HD_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  controlador_dma_hd_if.master   bus
);

  estado_t               state_q, state_d;
  logic                  dir_q;
  logic                  accept;
  logic                  load;
  logic                  step;
  logic                  chega_zero;
  logic                  engine;
  logic [HD_ADDR_W-1:0]  hd_cnt;
  logic [MEM_ADDR_W-1:0] mem_cnt;
  logic [DATA_W-1:0]     word;

  contador_enderecos_dma #(
    .HD_ADDR_W  (HD_ADDR_W),
    .MEM_ADDR_W (MEM_ADDR_W),
    .LEN_W      (LEN_W)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .hd_ini     (bus.cmd_hd_addr),
    .mem_ini    (bus.cmd_mem_addr),
    .len_ini    (bus.cmd_len),
    .hd_addr    (hd_cnt),
    .mem_addr   (mem_cnt),
    .chega_zero (chega_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_HD2MEM;
    end else begin
      state_q <= state_d;
      if (load) dir_q <= bus.cmd_dir;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_len != '0) begin
            load    = 1'b1;
            state_d = ST_RD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RD:   state_d = ST_WR;
      ST_WR: begin
        step    = 1'b1;
        state_d = chega_zero ? ST_FIN : ST_RD;
      end
      // cmd_valid is still high here (same instruction); it is ignored.
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Source read data for the current word, selected by the latched direction.
  assign word   = (dir_q == DIR_MEM2HD) ? bus.mem_rdata : bus.hd_rdata;
  assign engine = (state_q == ST_RD) || (state_q == ST_WR);

  always_comb begin
    bus.stall     = ((state_q == ST_IDLE) && bus.cmd_valid) || engine;
    bus.busy      = engine;
    bus.done      = (state_q == ST_FIN);
    bus.mem_we    = bus.cpu_mem_we;
    bus.mem_addr  = bus.cpu_mem_addr[MEM_ADDR_W-1:0];
    bus.mem_wdata = bus.cpu_mem_wdata;
    bus.hd_we     = 1'b0;
    bus.hd_addr   = hd_cnt;
    bus.hd_wdata  = word;
    if (engine) begin
      // The memory address is held over RD and WR: it is the read address in
      // RD for mem->HD and the write address in WR for HD->mem.
      bus.mem_addr  = mem_cnt;
      bus.mem_wdata = word;
      bus.mem_we    = (state_q == ST_WR) && (dir_q == DIR_HD2MEM);
      bus.hd_we     = (state_q == ST_WR) && (dir_q == DIR_MEM2HD);
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (step) begin
      checksum_q <= checksum_q ^ word;
    end
  end

  assign bus.checksum = checksum_q;
`else
  // accept only feeds the checksum register; fold it in harmlessly.
  assign bus.checksum = {DATA_W{accept & 1'b0}};
`endif

endmodule

// File: tb/tb_controlador_dma_hd.sv
// ---------------------------------------------------------------------------
// tb_controlador_dma_hd
// Directed bench for controlador_dma_hd: memory and HD models with 1-cycle
// read latency, directed command sequence, immediate-assertion checks.
// ---------------------------------------------------------------------------
module tb_controlador_dma_hd;
  import controlador_dma_hd_pkg::*;

  logic clk;
  logic reset;

  controlador_dma_hd_if bus ();

  controlador_dma_hd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem_m [0:1023];
  logic [31:0] hd_m  [0:65535];

  int checks = 0;
  int errors = 0;

  int          r_stall;
  int          r_mem_we;
  int          r_hd_we;
  int          r_done_cyc;
  logic        r_done_stall;
  logic [31:0] r_cs;
  logic [31:0] exp_cs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_rdata <= mem_m[bus.mem_addr];
    if (bus.mem_we) mem_m[bus.mem_addr] <= bus.mem_wdata;
    bus.hd_rdata <= hd_m[bus.hd_addr];
    if (bus.hd_we) hd_m[bus.hd_addr] <= bus.hd_wdata;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic dir, input logic [15:0] h, input logic [9:0] m,
                         input logic [8:0] len, input bit blk);
    bit seen;
    int lim;
    seen         = 1'b0;
    lim          = 2 * int'(len) + 8;
    r_stall      = 0;
    r_mem_we     = 0;
    r_hd_we      = 0;
    r_done_cyc   = -1;
    r_done_stall = 1'b1;
    r_cs         = 'x;
    @(negedge clk);
    bus.cmd_valid    = 1'b1;
    bus.cmd_dir      = dir;
    bus.cmd_hd_addr  = h;
    bus.cmd_mem_addr = m;
    bus.cmd_len      = len;
    #1;
    for (int c = 0; c < lim; c++) begin
      if (bus.stall)  r_stall++;
      if (bus.mem_we) r_mem_we++;
      if (bus.hd_we)  r_hd_we++;
      if (bus.done) begin
        seen          = 1'b1;
        r_done_cyc    = c;
        r_done_stall  = bus.stall;
        r_cs          = bus.checksum;
        bus.cmd_valid = 1'b0;
        break;
      end
      @(negedge clk);
      // Core tries to write during every RD/WR cycle when blk is set.
      bus.cpu_mem_we = blk && (c + 1 <= 2 * int'(len));
      #1;
    end
    bus.cpu_mem_we = 1'b0;
    bus.cmd_valid  = 1'b0;
    check("done seen", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    check("done pulse width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) hd_m[i] <= {16'hC0DE, i[15:0]};
    for (int i = 0; i < 1024; i++)  mem_m[i] <= 32'h0;
    hd_m[16'h0010] <= 32'hAAAA_0001;
    hd_m[16'h0011] <= 32'hBBBB_0002;
    hd_m[16'h0012] <= 32'hCCCC_0003;
    hd_m[16'h0200] <= 32'h0000_00F0;
    hd_m[16'h0201] <= 32'h0000_000F;
    hd_m[16'h0202] <= 32'h0000_00FF;
    mem_m[10'h3FF] <= 32'h1234_5678;
    mem_m[10'h000] <= 32'h9ABC_DEF0;

    reset             = 1'b0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_dir       = 1'b0;
    bus.cmd_hd_addr   = '0;
    bus.cmd_mem_addr  = '0;
    bus.cmd_len       = '0;
    bus.cpu_mem_we    = 1'b0;
    bus.cpu_mem_addr  = '0;
    bus.cpu_mem_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(dut.state_q), 32'(ST_IDLE));
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset hd_we", 32'(bus.hd_we), 32'd0);
    check("reset checksum", bus.checksum, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Core write passes through while idle
    @(negedge clk);
    bus.cpu_mem_we    = 1'b1;
    bus.cpu_mem_addr  = 32'd5;
    bus.cpu_mem_wdata = 32'h55;
    #1;
    check("idle pass mem_we", 32'(bus.mem_we), 32'd1);
    check("idle pass mem_addr", 32'(bus.mem_addr), 32'd5);
    check("idle pass stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.cpu_mem_we = 1'b0;
    #1;
    check("idle write mem[5]", mem_m[5], 32'h55);

    // HD->mem, 3 words, core write to addr 7 attempted during RD/WR
    bus.cpu_mem_addr  = 32'd7;
    bus.cpu_mem_wdata = 32'hDEAD_BEEF;
    run_cmd(DIR_HD2MEM, 16'h0010, 10'h004, 9'd3, 1'b1);
`ifdef DMA_CHECKSUM_EN
    exp_cs = 32'hDDDD_0000;
`else
    exp_cs = 32'h0;
`endif
    check("hd2mem stall cycles", 32'(r_stall), 32'd7);
    check("hd2mem done cycle", 32'(r_done_cyc), 32'd7);
    check("hd2mem stall at done", 32'(r_done_stall), 32'd0);
    check("hd2mem mem_we cycles", 32'(r_mem_we), 32'd3);
    check("hd2mem hd_we cycles", 32'(r_hd_we), 32'd0);
    check("hd2mem mem[4]", mem_m[4], 32'hAAAA_0001);
    check("hd2mem mem[5]", mem_m[5], 32'hBBBB_0002);
    check("hd2mem mem[6]", mem_m[6], 32'hCCCC_0003);
    check("blocked core write mem[7]", mem_m[7], 32'h0);
    check("hd2mem checksum at FIN", r_cs, exp_cs);
    check("hd2mem checksum held", bus.checksum, exp_cs);

    // Zero-length command
    run_cmd(DIR_HD2MEM, 16'h0040, 10'h040, 9'd0, 1'b0);
    check("len0 stall cycles", 32'(r_stall), 32'd1);
    check("len0 done cycle", 32'(r_done_cyc), 32'd1);
    check("len0 mem_we cycles", 32'(r_mem_we), 32'd0);
    check("len0 hd_we cycles", 32'(r_hd_we), 32'd0);
    check("len0 mem[0x40]", mem_m[10'h040], 32'h0);

    // Maximum length 256 with HD address wrap
    run_cmd(DIR_HD2MEM, 16'hFFF0, 10'h100, 9'd256, 1'b0);
    check("len256 stall cycles", 32'(r_stall), 32'd513);
    check("len256 done cycle", 32'(r_done_cyc), 32'd513);
    check("len256 mem_we cycles", 32'(r_mem_we), 32'd256);
    check("len256 first word", mem_m[10'h100], 32'hC0DE_FFF0);
    check("len256 wrapped word", mem_m[10'h110], 32'hC0DE_0000);
    check("len256 last word", mem_m[10'h1FF], 32'hC0DE_00EF);
    check("len256 past end", mem_m[10'h200], 32'h0);

    // mem->HD with memory address wrap
    run_cmd(DIR_MEM2HD, 16'h0000, 10'h3FF, 9'd2, 1'b0);
    check("mem2hd stall cycles", 32'(r_stall), 32'd5);
    check("mem2hd hd_we cycles", 32'(r_hd_we), 32'd2);
    check("mem2hd mem_we cycles", 32'(r_mem_we), 32'd0);
    check("mem2hd hd[0]", hd_m[0], 32'h1234_5678);
    check("mem2hd hd[1]", hd_m[1], 32'h9ABC_DEF0);
    check("mem2hd hd[2] untouched", hd_m[2], 32'hC0DE_0002);

    // Checksum words F0, 0F, FF -> 0
    run_cmd(DIR_HD2MEM, 16'h0200, 10'h300, 9'd3, 1'b0);
    check("cs mem[0x302]", mem_m[10'h302], 32'h0000_00FF);
    check("cs checksum at FIN", r_cs, 32'h0);
    @(negedge clk);
    #1;
    check("cs checksum held", bus.checksum, 32'h0);

    // Reset asserted mid-transfer (during RD of the third word)
    @(negedge clk);
    bus.cmd_valid    = 1'b1;
    bus.cmd_dir      = DIR_HD2MEM;
    bus.cmd_hd_addr  = 16'h0100;
    bus.cmd_mem_addr = 10'h020;
    bus.cmd_len      = 9'd5;
    #1;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b0;
    reset         = 1'b0;
    #1;
    check("midreset state", 32'(dut.state_q), 32'(ST_IDLE));
    check("midreset stall", 32'(bus.stall), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset mem_we", 32'(bus.mem_we), 32'd0);
    check("midreset hd_we", 32'(bus.hd_we), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset checksum", bus.checksum, 32'h0);
    check("midreset mem[0x20]", mem_m[10'h020], 32'hC0DE_0100);
    check("midreset mem[0x21]", mem_m[10'h021], 32'hC0DE_0101);
    check("midreset mem[0x22]", mem_m[10'h022], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("after reset mem[0x22]", mem_m[10'h022], 32'h0);

    // Commands still work after the reset
    run_cmd(DIR_HD2MEM, 16'h0300, 10'h050, 9'd1, 1'b0);
    check("post-reset stall cycles", 32'(r_stall), 32'd3);
    check("post-reset done cycle", 32'(r_done_cyc), 32'd3);
    check("post-reset mem[0x50]", mem_m[10'h050], 32'hC0DE_0300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_dma_hd.md
# controlador_dma_hd

Sequencer that copies blocks of 32-bit words between the HD model and data memory when the control unit flags an HD instruction (`HD_instr`). It stalls the processor for the whole transfer, owns the data-memory port while copying, and hands the port back to the core when idle. It sits between the single-cycle core, data memory and the HD.

## Interface
- `MEM_ADDR_W`, default 10: data-memory word-address width.
- `HD_ADDR_W`, default 16: HD word-address width.
- `LEN_W`, default 9: transfer-length width; length range is 0..256.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  HD instruction present (`HD_instr`); held by the core while stalled.
- `cmd_dir`  in  1  0 = HD→mem, 1 = mem→HD.
- `cmd_hd_addr`  in  HD_ADDR_W  first HD word.
- `cmd_mem_addr`  in  MEM_ADDR_W  first memory word.
- `cmd_len`  in  LEN_W  word count.
- `cpu_mem_we`, `cpu_mem_addr`, `cpu_mem_wdata`  in  1/32/32  core data-memory request.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/MEM_ADDR_W/32  data-memory port.
- `mem_rdata`  in  32  memory read data, valid 1 cycle after address.
- `hd_we`, `hd_addr`, `hd_wdata`  out  1/HD_ADDR_W/32  HD port.
- `hd_rdata`  in  32  HD read data, valid 1 cycle after address.
- `stall`  out  1  freezes the PC and register writes.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  32  XOR of transferred words.

## Operation
- FSM states: IDLE, RD, WR, FIN.
- IDLE:
  - `cmd_valid`=1 and `cmd_len`≠0: latch addresses, length and direction; go to RD.
  - `cmd_valid`=1 and `cmd_len`=0: go to FIN.
- RD: drive the source address (`hd_addr` or `mem_addr`); go to WR.
- WR:
  - Write the source read data to the destination address.
  - Increment both address counters and decrement the remaining count.
  - Remaining count becomes 0: go to FIN; otherwise go to RD.
- FIN: `done`=1; go to IDLE. `cmd_valid` is ignored in FIN, because the same instruction is still present.
- `stall` = (IDLE & `cmd_valid`) | RD | WR. It is combinational and low in FIN, so the core retires the instruction.
- `busy` = RD | WR.
- Port ownership:
  - IDLE/FIN: memory outputs pass the `cpu_*` inputs through; `hd_we`=0.
  - RD/WR: the engine owns the memory port and `cpu_mem_we` is forced low.
- Addresses wrap modulo 2^width; there is no error on wrap.
- The length counter is LEN_W bits; 256 is a legal value.

## Timing
- Reset values: state IDLE; `stall`, `busy`, `done`, `mem_we`, `hd_we` = 0; counters and `checksum` = 0.
- Transfer of N>0 words:
  - Stall lasts 2N+1 cycles, counted from the IDLE cycle where `cmd_valid` is seen.
  - `done` is asserted in cycle 2N+1, with `stall`=0.
- N=0: stall lasts 1 cycle, and `done` is asserted in the next cycle.
- Destination write `we` is high only in WR cycles.
- Reset asserted mid-transfer:
  - Immediate return to IDLE with all outputs at their reset values.
  - Words already written remain; the transfer is not resumed.
- A new command is accepted no earlier than the cycle after FIN.

## Configuration
- `DMA_CHECKSUM_EN` defined:
  - `checksum` is cleared when a command is accepted.
  - Each WR cycle XORs the transferred word into `checksum`.
  - The value is stable from FIN until the next accept.
- Not defined: `checksum` is tied to 0 and no checksum register is built.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, RD=1, WR=2, FIN=3)
  - direction constants `DIR_HD2MEM`/`DIR_MEM2HD`
  - default widths.
- One sub-module, `contador_enderecos_dma`, contains:
  - the loadable HD and memory address counters
  - the remaining-length down-counter with a zero flag.

## Test plan
- Reset low during RD/WR → state IDLE, `stall`=0, `mem_we`=0, `hd_we`=0; later commands still work.
- `cmd_dir`=0, hd 0x0010, mem 0x004, len 3, HD holds A,B,C:
  - Expected: mem[4..6]=A,B,C.
  - `stall` high for 7 cycles; `done` in cycle 7.
- `cmd_dir`=1, mem 0x3FF, hd 0x0000, len 2:
  - Expected: hd[0]=mem[0x3FF], hd[1]=mem[0x000], showing memory wrap.
- `cmd_len`=0 → one stall cycle, then a `done` pulse; no writes.
- Core write while idle (addr 5, data 0x55) passes through. `cpu_mem_we`=1 during WR is blocked.
- `DMA_CHECKSUM_EN` with words 0xF0, 0x0F, 0xFF → `checksum`=0x00 at FIN.
